// File: rtl/contador_lectura.sv
`default_nettype none
// ============================================================================
// Module   : contador_lectura
// Brief    : Read-cycle timing generator for the multiplexed address/data RTC
//            bus (address phase, turnaround, RD strobe, byte capture).
//            Optional macro READ_DOUBLE_SAMPLE_EN adds double sampling with a
//            single retry and the error_lectura flag.
// Revision : 1.0 - initial release
// ============================================================================
module contador_lectura #(
    parameter int unsigned T_AS = 2,
    parameter int unsigned T_WR = 6,
    parameter int unsigned T_AH = 2,
    parameter int unsigned T_TA = 2,
    parameter int unsigned T_RD = 6,
    parameter int unsigned T_RC = 2
) (
    input  logic       clkRD,
    input  logic       resetRD,
    input  logic       inicio,
    input  logic [7:0] direccion,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       DIR,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic [7:0] dato,
    output logic       dato_valido,
    output logic       ocupado
`ifdef READ_DOUBLE_SAMPLE_EN
    ,
    output logic       error_lectura
`endif
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ADDR_SETUP = 3'd1;
    localparam logic [2:0] S_ADDR_WR    = 3'd2;
    localparam logic [2:0] S_ADDR_HOLD  = 3'd3;
    localparam logic [2:0] S_TURN       = 3'd4;
    localparam logic [2:0] S_READ       = 3'd5;
    localparam logic [2:0] S_RECOVER    = 3'd6;
`ifdef READ_DOUBLE_SAMPLE_EN
    localparam logic [2:0] S_GAP        = 3'd7;
`endif

    localparam logic [3:0] c_as_last = 4'(T_AS - 1);
    localparam logic [3:0] c_wr_last = 4'(T_WR - 1);
    localparam logic [3:0] c_ah_last = 4'(T_AH - 1);
    localparam logic [3:0] c_ta_last = 4'(T_TA - 1);
    localparam logic [3:0] c_rd_last = 4'(T_RD - 1);
    localparam logic [3:0] c_rc_last = 4'(T_RC - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] w_addr_nxt;
    logic       w_accept;
    logic       w_capture;

    logic       w_cs;
    logic       w_rd;
    logic       w_wr;
    logic       w_ad;
    logic       w_dir;
    logic       w_ocup;
    logic [7:0] w_bus;

`ifdef READ_DOUBLE_SAMPLE_EN
    localparam logic [3:0] c_rd_prev = 4'(T_RD - 2);
    logic [7:0] r_samp;
    logic       r_retry;
    logic       w_mismatch;
    assign w_mismatch = (bus_in != r_samp);
`endif

    assign w_accept   = (r_state == S_IDLE) && inicio;
    assign w_addr_nxt = w_accept ? direccion : r_addr;
    assign w_capture  = (r_state == S_READ) && (r_cnt == c_rd_last) &&
                        (w_state_nxt == S_RECOVER);

    // State register and phase counter
    always_ff @(posedge clkRD or negedge resetRD) begin
        if (!resetRD) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (inicio)               w_state_nxt = S_ADDR_SETUP;
            S_ADDR_SETUP: if (r_cnt == c_as_last)   w_state_nxt = S_ADDR_WR;
            S_ADDR_WR:    if (r_cnt == c_wr_last)   w_state_nxt = S_ADDR_HOLD;
            S_ADDR_HOLD:  if (r_cnt == c_ah_last)   w_state_nxt = S_TURN;
            S_TURN:       if (r_cnt == c_ta_last)   w_state_nxt = S_READ;
            S_READ: begin
                if (r_cnt == c_rd_last) begin
                    w_state_nxt = S_RECOVER;
`ifdef READ_DOUBLE_SAMPLE_EN
                    if (!r_retry && w_mismatch) w_state_nxt = S_GAP;
`endif
                end
            end
`ifdef READ_DOUBLE_SAMPLE_EN
            S_GAP:                                  w_state_nxt = S_READ;
`endif
            S_RECOVER:    if (r_cnt == c_rc_last)   w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode on the next state so every bus line leaves a flop
    always_comb begin
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_wr   = 1'b1;
        w_ad   = 1'b1;
        w_dir  = 1'b0;
        w_bus  = 8'd0;
        w_ocup = 1'b1;
        case (w_state_nxt)
            S_IDLE: w_ocup = 1'b0;
            S_ADDR_SETUP, S_ADDR_HOLD: begin
                w_cs  = 1'b0;
                w_ad  = 1'b0;
                w_dir = 1'b1;
                w_bus = w_addr_nxt;
            end
            S_ADDR_WR: begin
                w_cs  = 1'b0;
                w_ad  = 1'b0;
                w_dir = 1'b1;
                w_wr  = 1'b0;
                w_bus = w_addr_nxt;
            end
            S_TURN: w_cs = 1'b0;
            S_READ: begin
                w_cs = 1'b0;
                w_rd = 1'b0;
            end
`ifdef READ_DOUBLE_SAMPLE_EN
            S_GAP: w_cs = 1'b0;
`endif
            S_RECOVER: w_cs = 1'b1;
            default: w_ocup = 1'b0;
        endcase
    end

    always_ff @(posedge clkRD or negedge resetRD) begin
        if (!resetRD) begin
            CS          <= 1'b1;
            RD          <= 1'b1;
            WR          <= 1'b1;
            AD          <= 1'b1;
            DIR         <= 1'b0;
            bus_out     <= 8'd0;
            ocupado     <= 1'b0;
            dato        <= 8'd0;
            dato_valido <= 1'b0;
        end else begin
            CS          <= w_cs;
            RD          <= w_rd;
            WR          <= w_wr;
            AD          <= w_ad;
            DIR         <= w_dir;
            bus_out     <= w_bus;
            ocupado     <= w_ocup;
            dato_valido <= w_capture;
            if (w_capture) begin
                dato <= bus_in;
            end
        end
    end

`ifdef READ_DOUBLE_SAMPLE_EN
    // Early sample, retry flag and error flag for the double-sample read
    always_ff @(posedge clkRD or negedge resetRD) begin
        if (!resetRD) begin
            r_samp        <= 8'd0;
            r_retry       <= 1'b0;
            error_lectura <= 1'b0;
        end else begin
            if ((r_state == S_READ) && (r_cnt == c_rd_prev)) begin
                r_samp <= bus_in;
            end
            if (w_accept) begin
                r_retry       <= 1'b0;
                error_lectura <= 1'b0;
            end else begin
                if (w_state_nxt == S_GAP) begin
                    r_retry <= 1'b1;
                end
                if (w_capture && r_retry && w_mismatch) begin
                    error_lectura <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_contador_lectura.sv
`default_nettype none
// Testbench for contador_lectura: cycle-accurate bus vector checks plus a
// scoreboard of expected captured bytes.
module tb_contador_lectura;

    logic       clkRD;
    logic       resetRD;
    logic       inicio;
    logic [7:0] direccion;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       DIR, CS, RD, WR, AD;
    logic [7:0] dato;
    logic       dato_valido;
    logic       ocupado;
`ifdef READ_DOUBLE_SAMPLE_EN
    logic       error_lectura;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];
    logic [13:0] dut_vec;

    contador_lectura dut (
        .clkRD       (clkRD),
        .resetRD     (resetRD),
        .inicio      (inicio),
        .direccion   (direccion),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .DIR         (DIR),
        .CS          (CS),
        .RD          (RD),
        .WR          (WR),
        .AD          (AD),
        .dato        (dato),
        .dato_valido (dato_valido),
        .ocupado     (ocupado)
`ifdef READ_DOUBLE_SAMPLE_EN
        ,
        .error_lectura (error_lectura)
`endif
    );

    assign dut_vec = {dato_valido, ocupado, CS, RD, WR, AD, DIR, bus_out};

    initial clkRD = 1'b0;
    always #5 clkRD = ~clkRD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {dato_valido, ocupado, CS, RD, WR, AD, DIR, bus_out} for
    // cycle k after the accept edge of a default-timing read.
    function automatic logic [13:0] exp_vec(input int k, input logic [7:0] a);
        if (k < 2)       return {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a};
        else if (k < 8)  return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a};
        else if (k < 10) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a};
        else if (k < 12) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        else if (k < 18) return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        else if (k < 20) return {(k == 18), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        else             return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    endfunction

    // Scoreboard monitor: every dato_valido pulse pops one expected byte
    always @(negedge clkRD) begin
        if (resetRD && dato_valido) begin
            if (sb_q.size() == 0) check("sb_spurious_valid", 32'd1, 32'd0);
            else                  check("sb_dato", 32'(dato), 32'(sb_q.pop_front()));
        end
    end

    // Called right after a negedge; returns at the negedge of cycle 20.
    task automatic txn(input logic [7:0] a, input logic [7:0] d, input bit hold, input bit ign);
        direccion = a;
        inicio    = 1'b1;
        bus_in    = ~d;
        sb_q.push_back(d);
        @(posedge clkRD);
        for (int k = 0; k < 20; k++) begin
            @(negedge clkRD);
            check($sformatf("vec_a%02h_k%0d", a, k), 32'(dut_vec), 32'(exp_vec(k, a)));
            if (k == 0 && !hold) inicio = 1'b0;
            if (ign && k == 5) begin
                inicio    = 1'b1;
                direccion = 8'h33;
            end
            if (ign && k == 6) inicio = 1'b0;
            bus_in = (k == 16 || k == 17) ? d : ~d;
        end
        @(negedge clkRD);
        check($sformatf("idle_a%02h", a), 32'(dut_vec), 32'(exp_vec(20, a)));
    endtask

`ifdef READ_DOUBLE_SAMPLE_EN
    task automatic txn_retry(input bit bad);
        logic [7:0] fin;
        fin       = bad ? 8'h55 : 8'h22;
        direccion = 8'h40;
        inicio    = 1'b1;
        bus_in    = 8'h00;
        sb_q.push_back(fin);
        @(posedge clkRD);
        for (int k = 0; k < 28; k++) begin
            @(negedge clkRD);
            if (k == 0) begin
                inicio = 1'b0;
                check("err_clear", 32'(error_lectura), 32'd0);
            end
            check($sformatf("retry_rd_k%0d", k), 32'(RD),
                  32'(!((k >= 12 && k <= 17) || (k >= 19 && k <= 24))));
            check($sformatf("retry_ocup_k%0d", k), 32'(ocupado), 32'(k < 27));
            if (k == 25 || k == 27) check("err_flag", 32'(error_lectura), 32'(bad));
            if (k == 16)      bus_in = 8'h11;
            else if (k == 17) bus_in = 8'h22;
            else if (k == 23) bus_in = bad ? 8'h44 : 8'h22;
            else if (k == 24) bus_in = fin;
            else if (k > 17)  bus_in = 8'h22;
        end
    endtask
`endif

    initial begin
        resetRD   = 1'b0;
        inicio    = 1'b0;
        direccion = 8'h00;
        bus_in    = 8'h00;
        repeat (3) @(negedge clkRD);
        resetRD = 1'b1;
        @(negedge clkRD);
        check("reset_vec", 32'(dut_vec), 32'(exp_vec(20, 8'h00)));
        check("reset_dato", 32'(dato), 32'h00);

        // Single read with an ignored start request mid-transaction
        txn(8'h21, 8'hA5, 1'b0, 1'b1);
        @(negedge clkRD);

        // Back-to-back with inicio held high: one idle cycle in between
        txn(8'h10, 8'h5A, 1'b1, 1'b0);
        txn(8'h11, 8'hC3, 1'b1, 1'b0);
        inicio = 1'b0;
        @(negedge clkRD);
        check("b2b_stop", 32'(ocupado), 32'd0);
        check("b2b_dato", 32'(dato), 32'hC3);

        // Asynchronous reset during READ aborts without any capture
        direccion = 8'h77;
        inicio    = 1'b1;
        bus_in    = 8'h99;
        @(posedge clkRD);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clkRD);
            if (k == 0) inicio = 1'b0;
        end
        check("pre_rst_rd", 32'(RD), 32'd0);
        #2 resetRD = 1'b0;
        #1;
        check("midrst_vec", 32'(dut_vec), 32'(exp_vec(20, 8'h00)));
        check("midrst_dato", 32'(dato), 32'h00);
        @(negedge clkRD);
        @(negedge clkRD);
        resetRD = 1'b1;
        repeat (25) @(negedge clkRD);
        check("post_rst_idle", 32'(dut_vec), 32'(exp_vec(20, 8'h00)));
        check("post_rst_dato", 32'(dato), 32'h00);

`ifdef READ_DOUBLE_SAMPLE_EN
        txn_retry(1'b0);
        txn_retry(1'b1);
        @(negedge clkRD);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contador_lectura.md
Name: contador_lectura

Overview:
- Read-cycle timing generator for the multiplexed address/data RTC bus; complements the existing write/address sequencer.
- On a start request it drives the register address onto the bus (address phase), turns the bus around, strobes RD, and captures the returned byte.
- Sits between the RTC control FSM and the bidirectional bus pad logic. It shares the CS/RD/WR/AD/DIR lines through the top-level bus mux.

Parameters:
- T_AS, 2, address setup cycles (CS=0, AD=0, WR=1) before WR strobe; range 1..15
- T_WR, 6, WR low cycles latching the address; range 1..15
- T_AH, 2, address hold cycles after WR rises; range 1..15
- T_TA, 2, bus turnaround cycles (DIR=0, RD=1) before RD strobe; range 1..15
- T_RD, 6, RD low cycles; data sampled on last one; range 2..15
- T_RC, 2, recovery cycles with CS=1 before returning to idle; range 1..15

Ports:
- clkRD  input  1  system clock, all logic on rising edge
- resetRD  input  1  asynchronous, active-low reset
- inicio  input  1  start request, sampled only in IDLE
- direccion  input  8  RTC register address, latched when inicio is accepted
- bus_in  input  8  data from the bidirectional bus pad
- bus_out  output  8  data to the bus pad (address during address phase, else 0)
- DIR  output  1  1 = FPGA drives bus, 0 = bus released/input
- CS  output  1  chip select, active low
- RD  output  1  read strobe, active low
- WR  output  1  write strobe, active low
- AD  output  1  0 = address phase, 1 = data phase
- dato  output  8  last byte read, held until the next capture
- dato_valido  output  1  one-cycle pulse when dato is updated
- ocupado  output  1  1 while a transaction is in progress

Behaviour:
- Reset (resetRD=0, asynchronous): state=IDLE, CS=1, RD=1, WR=1, AD=1, DIR=0, bus_out=0, dato=0, dato_valido=0, ocupado=0, counter=0, address register=0.
- Reset asserted mid-transaction aborts immediately to these values. No partial dato update occurs.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE -> ADDR_SETUP -> ADDR_WR -> ADDR_HOLD -> TURN -> READ -> RECOVER -> IDLE.
- Each state lasts exactly its parameter count of cycles. A single 4-bit phase counter reloads to 0 on every state change.
- IDLE: idle output values, ocupado=0. If inicio=1 on a clock edge, latch direccion and enter ADDR_SETUP.
- ADDR_SETUP: CS=0, AD=0, DIR=1, bus_out=address, WR=1, RD=1.
- ADDR_WR: same as ADDR_SETUP with WR=0.
- ADDR_HOLD: WR=1; CS=0, AD=0, DIR=1, bus_out=address are held.
- TURN: DIR=0, bus_out=0, AD=1, CS=0, RD=1.
- READ: RD=0, CS=0, AD=1, DIR=0. On the edge ending the last READ cycle, bus_in is registered into dato.
- RECOVER: RD=1, CS=1, AD=1, DIR=0. dato_valido=1 during the first RECOVER cycle only.
- ocupado=1 in every non-IDLE state.
- Default total transaction: 20 cycles from the accept edge to return to IDLE.
- inicio asserted outside IDLE is ignored; no queuing.
- inicio held high continuously starts a new transaction on the first IDLE cycle. That gives one idle cycle between back-to-back transactions.
- RD and WR are never low simultaneously. DIR is never 1 while RD=0.

Optional Feature:
- Macro: READ_DOUBLE_SAMPLE_EN
- Defined: bus_in is sampled on both of the last two READ cycles.
  - If the samples match, behaviour is as baseline.
  - If they differ, READ is repeated once with RD returning high for 1 cycle between attempts, then the second attempt's final sample is captured.
  - Adds output error_lectura (1 bit, reset 0). It is set on a mismatch in the repeated attempt, held until the next accepted inicio, and the byte is still captured.
- Undefined: single sample on the last READ cycle, no retry, no error_lectura port.

Test Plan:
- Reset then idle: resetRD=0 for 3 cycles, release -> CS=1, RD=1, WR=1, AD=1, DIR=0, ocupado=0, dato=0h00.
- Single read: direccion=0x21, inicio pulse 1 cycle, bus_in=0xA5 during READ -> WR low cycles 2..7 with bus_out=0x21 and DIR=1; RD low cycles 12..17; dato=0xA5 with dato_valido=1 at cycle 18; ocupado=0 at cycle 20.
- Ignored start: inicio re-pulsed at cycle 5 with direccion=0x33 -> no effect; bus_out stays 0x21 through the address phase.
- Back-to-back: inicio held high, addresses 0x10 then 0x11, bus_in 0x5A then 0xC3 -> two transactions separated by exactly 1 idle cycle; dato sequence 0x5A, 0xC3.
- Mid-transaction reset: resetRD=0 asynchronously during READ -> outputs go to idle values immediately; dato=0, no dato_valido pulse.
- (READ_DOUBLE_SAMPLE_EN) bus_in changes 0x11 -> 0x22 on the last READ cycle -> RD high 1 cycle, RD low again for 6 cycles, dato=0x22, error_lectura follows the second attempt's comparison.
